ups_axi4l_regs: RTL and testbench
=================================

Name: ups_axi4l_regs

Overview:
AXI4-Lite responder (slave) register bank on the ca4l_ interface, fed by the PS-side / testbench AXI4-Lite initiator. Holds NUM_REGS 32-bit read/write control registers at word-aligned offsets 0x0, 0x4, 0x8, and so on. Register contents are exported to UPS fabric logic. Serves one transaction at a time; writes take priority over reads.

Parameters:
NUM_REGS, 4, number of 32-bit registers; decoded offsets are 0x0 to 4*(NUM_REGS-1).
ADDR_WIDTH, 32, width of ca4l_awaddr and ca4l_araddr.
STRB_EN, 0, 0 means ca4l_wstrb is ignored and full words are written; 1 means byte lanes are honoured.
RST_VAL, 32'h0, reset value of every register.

Ports:
fclk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
ca4l_awaddr  in  ADDR_WIDTH  write address.
ca4l_awprot  in  3  ignored.
ca4l_awvalid / ca4l_awready  in / out  1  write-address handshake.
ca4l_wdata  in  32  write data.
ca4l_wstrb  in  4  byte strobes; used only when STRB_EN=1.
ca4l_wvalid / ca4l_wready  in / out  1  write-data handshake.
ca4l_bresp  out  2  write response.
ca4l_bvalid / ca4l_bready  out / in  1  write-response handshake.
ca4l_araddr  in  ADDR_WIDTH  read address.
ca4l_arprot  in  3  ignored.
ca4l_arvalid / ca4l_arready  in / out  1  read-address handshake.
ca4l_rdata  out  32  read data.
ca4l_rresp  out  2  read response.
ca4l_rvalid / ca4l_rready  out / in  1  read-data handshake.
reg_out  out  NUM_REGS*32  register contents; register i occupies bits [32*i+31:32*i].
reg_wr_stb  out  NUM_REGS  one-cycle pulse per register on a successful write.

Behaviour:
- Reset (async, rst_n=0):
  - all ready/valid outputs 0; bresp, rresp, rdata 0; reg_wr_stb 0.
  - all registers = RST_VAL; FSM = IDLE.
  - Asserting rst_n mid-transaction drops that transaction; no response is issued.
- Address decode:
  - addr[1:0] ignored; index = addr[ADDR_WIDTH-1:2].
  - index >= NUM_REGS is out of range.
- Response codes: OKAY=2'b00, SLVERR=2'b10.
- FSM states: IDLE, AW_HAVE, W_HAVE, B_RESP, R_DATA.
- Ready decode:
  - ca4l_awready = state in {IDLE, W_HAVE}.
  - ca4l_wready = state in {IDLE, AW_HAVE}.
  - ca4l_arready = (state==IDLE) && !ca4l_awvalid && !ca4l_wvalid. This is combinational and gives writes priority.
- Transitions out of IDLE:
  - AW and W handshake in the same cycle -> commit write -> B_RESP.
  - AW handshake only -> latch address -> AW_HAVE.
  - W handshake only -> latch data and strobes -> W_HAVE.
  - AR handshake -> latch index -> R_DATA.
- AW_HAVE: on W handshake -> commit -> B_RESP.
- W_HAVE: on AW handshake -> commit -> B_RESP.
- Commit (at the edge of the completing handshake):
  - In range: write register; bits updated = all if STRB_EN=0, else lanes with wstrb=1.
  - reg_wr_stb[index] is 1 for the following cycle only.
  - bresp = OKAY in range; SLVERR out of range, with no register change and no strobe.
- B_RESP:
  - bvalid=1 from the cycle after commit; held with bresp stable until bready=1.
  - Handshake edge -> bvalid=0 -> IDLE.
  - Write latency: bvalid rises 1 cycle after the last write handshake.
- R_DATA:
  - rvalid=1 from the cycle after the AR handshake.
  - rdata = register value (post any earlier write); rresp=OKAY.
  - Out of range: rdata=0, rresp=SLVERR.
  - Held stable until rready=1; handshake edge -> rvalid=0, rdata=0 -> IDLE.
- No outstanding-transaction pipelining; at most one of bvalid or rvalid is ever high.
- AR pending during a write: waits; it is accepted in IDLE once no AW or W is valid.

Decomposition:
- Package ups_axi4l_pkg holds:
  - AXI_RESP_OKAY, AXI_RESP_SLVERR localparams;
  - typedef enum logic [2:0] axi4l_slv_state_t {IDLE, AW_HAVE, W_HAVE, B_RESP, R_DATA};
  - a 32-bit data typedef.
- One natural sub-module: ups_axi4l_regbank, containing the register array, strobe masking, reg_wr_stb generation and the read mux. The FSM and handshakes stay in the top.

Test Plan:
- Basic write/read sequence with strobes 0 and STRB_EN=0:
  - write 0x0=0x2 -> bresp=00 and reg_wr_stb[0] pulses; read 0x0 -> 0x00000002, rresp=00.
  - write 0x4=0x11, read 0x4 -> 0x00000011.
  - write 0x8=0xC38D -> reg_out[95:64]=0x0000C38D.
- AW first, then W one cycle later (sequential initiator) -> FSM passes through AW_HAVE; bvalid rises 1 cycle after the W handshake.
- W before AW, and AW+W in the same cycle -> both commit correctly. Also hold bready=0 for 5 cycles -> bvalid and bresp stay stable, and arready stays 0 throughout.
- Out of range (NUM_REGS=4) at addr 0x10:
  - write 0xDEAD -> bresp=10, no reg_wr_stb, registers unchanged;
  - read -> rdata=0, rresp=10.
- STRB_EN=1: reg1=0xFFFFFFFF, write 0x12345678 with wstrb=4'b0011 -> read 0x4 returns 0xFFFF5678.
- Reset mid-transaction:
  - assert rst_n=0 while in AW_HAVE -> all outputs 0 immediately (asynchronous) and registers = RST_VAL;
  - after release, a new write to 0x0 completes normally.

Source files
------------

// File: rtl/ups_axi4l_pkg.sv
// Shared types and constants for the UPS AXI4-Lite control register block.
package ups_axi4l_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef logic [31:0] axi4l_data_t;

    typedef enum logic [2:0] {
        IDLE,
        AW_HAVE,
        W_HAVE,
        B_RESP,
        R_DATA
    } axi4l_slv_state_t;

    function automatic axi4l_data_t strb_to_mask(input logic [3:0] strb);
        axi4l_data_t mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ups_axi4l_regbank.sv
// Register array behind the AXI4-Lite responder: byte-masked writes,
// one-cycle write strobes and the combinational read mux.
module ups_axi4l_regbank
    import ups_axi4l_pkg::*;
#(
    parameter int          NUM_REGS = 4,
    parameter int          IDX_W    = 2,
    parameter bit          STRB_EN  = 1'b0,
    parameter logic [31:0] RST_VAL  = 32'h0
) (
    input  logic                     fclk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  logic [31:0]              i_wr_data,
    input  logic [3:0]               i_wr_strb,
    input  logic [IDX_W-1:0]         i_rd_idx,
    output logic [31:0]              o_rd_data,
    output logic [NUM_REGS*32-1:0]   o_reg_out,
    output logic [NUM_REGS-1:0]      o_wr_stb
);

    axi4l_data_t               w_mask;
    logic [NUM_REGS-1:0]       w_hit;
    logic [NUM_REGS*32-1:0]    w_flat;
    logic [NUM_REGS-1:0]       r_wr_stb;

    assign w_mask = STRB_EN ? strb_to_mask(i_wr_strb) : '1;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [31:0] r_reg;

        assign w_hit[i] = i_wr_en && (i_wr_idx == IDX_W'(i));

        // NOTE: each register is a discrete flop with async reset, not an unreset RAM, so reg_out is defined from the moment rst_n asserts.
        always_ff @(posedge fclk or negedge rst_n) begin
            if (!rst_n) begin
                r_reg <= RST_VAL;
            end else if (w_hit[i]) begin
                r_reg <= (r_reg & ~w_mask) | (i_wr_data & w_mask);
            end
        end

        assign w_flat[32*i +: 32] = r_reg;
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_stb <= '0;
        end else begin
            r_wr_stb <= w_hit;
        end
    end

    // NOTE: default assignment first keeps this mux latch-free; blocking '=' is the right form inside combinational logic.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                o_rd_data = w_flat[32*i +: 32];
            end
        end
    end

    assign o_reg_out = w_flat;
    assign o_wr_stb  = r_wr_stb;

endmodule

// File: rtl/ups_axi4l_regs.sv
// AXI4-Lite responder exporting NUM_REGS control registers to UPS fabric.
// One transaction at a time; a pending write always wins over a read.
module ups_axi4l_regs
    import ups_axi4l_pkg::*;
#(
    parameter int          NUM_REGS   = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter bit          STRB_EN    = 1'b0,
    parameter logic [31:0] RST_VAL    = 32'h0
) (
    input  logic                     fclk,
    input  logic                     rst_n,
    input  logic [ADDR_WIDTH-1:0]    ca4l_awaddr,
    input  logic [2:0]               ca4l_awprot,
    input  logic                     ca4l_awvalid,
    output logic                     ca4l_awready,
    input  logic [31:0]              ca4l_wdata,
    input  logic [3:0]               ca4l_wstrb,
    input  logic                     ca4l_wvalid,
    output logic                     ca4l_wready,
    output logic [1:0]               ca4l_bresp,
    output logic                     ca4l_bvalid,
    input  logic                     ca4l_bready,
    input  logic [ADDR_WIDTH-1:0]    ca4l_araddr,
    input  logic [2:0]               ca4l_arprot,
    input  logic                     ca4l_arvalid,
    output logic                     ca4l_arready,
    output logic [31:0]              ca4l_rdata,
    output logic [1:0]               ca4l_rresp,
    output logic                     ca4l_rvalid,
    input  logic                     ca4l_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_stb
);

    localparam int                IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int                AIDX_W    = ADDR_WIDTH - 2;
    localparam logic [AIDX_W-1:0] IDX_LIMIT = AIDX_W'(NUM_REGS);

    axi4l_slv_state_t   r_state;
    logic               r_active;
    logic [AIDX_W-1:0]  r_aw_idx;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_commit;
    logic               w_cmt_in_range;
    logic               w_ar_in_range;
    logic [AIDX_W-1:0]  w_aw_idx;
    logic [AIDX_W-1:0]  w_ar_idx;
    logic [AIDX_W-1:0]  w_cmt_idx;
    logic [31:0]        w_cmt_data;
    logic [3:0]         w_cmt_strb;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    assign w_aw_idx = ca4l_awaddr[ADDR_WIDTH-1:2];
    assign w_ar_idx = ca4l_araddr[ADDR_WIDTH-1:2];

    // r_active holds every ready low while rst_n is asserted, even though the FSM sits in IDLE.
    assign ca4l_awready = r_active && (r_state == IDLE || r_state == W_HAVE);
    assign ca4l_wready  = r_active && (r_state == IDLE || r_state == AW_HAVE);
    assign ca4l_arready = r_active && (r_state == IDLE) && !ca4l_awvalid && !ca4l_wvalid;

    assign w_aw_hs = ca4l_awvalid && ca4l_awready;
    assign w_w_hs  = ca4l_wvalid  && ca4l_wready;
    assign w_ar_hs = ca4l_arvalid && ca4l_arready;

    assign w_commit = ((r_state == IDLE)    && w_aw_hs && w_w_hs)
                   || ((r_state == AW_HAVE) && w_w_hs)
                   || ((r_state == W_HAVE)  && w_aw_hs);

    assign w_cmt_idx      = (r_state == AW_HAVE) ? r_aw_idx : w_aw_idx;
    assign w_cmt_data     = (r_state == W_HAVE)  ? r_wdata  : ca4l_wdata;
    assign w_cmt_strb     = (r_state == W_HAVE)  ? r_wstrb  : ca4l_wstrb;
    assign w_cmt_in_range = (w_cmt_idx < IDX_LIMIT);
    assign w_ar_in_range  = (w_ar_idx  < IDX_LIMIT);

    ups_axi4l_regbank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .STRB_EN  (STRB_EN),
        .RST_VAL  (RST_VAL)
    ) u_regbank (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .i_wr_en   (w_commit && w_cmt_in_range),
        .i_wr_idx  (w_cmt_idx[IDX_W-1:0]),
        .i_wr_data (w_cmt_data),
        .i_wr_strb (w_cmt_strb),
        .i_rd_idx  (w_ar_idx[IDX_W-1:0]),
        .o_rd_data (w_rd_data),
        .o_reg_out (reg_out),
        .o_wr_stb  (reg_wr_stb)
    );

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
            r_aw_idx <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= AXI_RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= AXI_RESP_OKAY;
        end else begin
            r_active <= 1'b1;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_cmt_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                r_state  <= B_RESP;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_aw_hs) begin
                            r_aw_idx <= w_aw_idx;
                            r_state  <= AW_HAVE;
                        end else if (w_w_hs) begin
                            r_wdata  <= ca4l_wdata;
                            r_wstrb  <= ca4l_wstrb;
                            r_state  <= W_HAVE;
                        end else if (w_ar_hs) begin
                            // No write can land while in R_DATA, so the value captured here stays valid.
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_ar_in_range ? w_rd_data : '0;
                            r_rresp  <= w_ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                            r_state  <= R_DATA;
                        end
                    end
                    B_RESP: begin
                        if (ca4l_bready) begin
                            r_bvalid <= 1'b0;
                            r_bresp  <= AXI_RESP_OKAY;
                            r_state  <= IDLE;
                        end
                    end
                    R_DATA: begin
                        if (ca4l_rready) begin
                            r_rvalid <= 1'b0;
                            r_rdata  <= '0;
                            r_rresp  <= AXI_RESP_OKAY;
                            r_state  <= IDLE;
                        end
                    end
                    AW_HAVE, W_HAVE: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ca4l_bvalid = r_bvalid;
    assign ca4l_bresp  = r_bresp;
    assign ca4l_rvalid = r_rvalid;
    assign ca4l_rdata  = r_rdata;
    assign ca4l_rresp  = r_rresp;

    assign w_unused = ^{ca4l_awprot, ca4l_arprot, ca4l_awaddr[1:0], ca4l_araddr[1:0]};

endmodule

// File: tb/tb_ups_axi4l_regs.sv
// Self-checking bench: two responders (STRB_EN=0 and STRB_EN=1) share one
// initiator; a scoreboard queue holds the expected B/R response of each.
module tb_ups_axi4l_regs;

    logic         fclk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  ca4l_awaddr = '0;
    logic [2:0]   ca4l_awprot = '0;
    logic         ca4l_awvalid = 1'b0;
    logic [31:0]  ca4l_wdata = '0;
    logic [3:0]   ca4l_wstrb = '0;
    logic         ca4l_wvalid = 1'b0;
    logic         ca4l_bready = 1'b0;
    logic [31:0]  ca4l_araddr = '0;
    logic [2:0]   ca4l_arprot = '0;
    logic         ca4l_arvalid = 1'b0;
    logic         ca4l_rready = 1'b0;

    logic         awready_0, wready_0, bvalid_0, arready_0, rvalid_0;
    logic [1:0]   bresp_0, rresp_0;
    logic [31:0]  rdata_0;
    logic [127:0] reg_out_0;
    logic [3:0]   reg_wr_stb_0;

    logic         awready_1, wready_1, bvalid_1, arready_1, rvalid_1;
    logic [1:0]   bresp_1, rresp_1;
    logic [31:0]  rdata_1;
    logic [127:0] reg_out_1;
    logic [3:0]   reg_wr_stb_1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data0;
        logic [31:0] data1;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl0 [4];
    logic [31:0] mdl1 [4];

    always #5 fclk = ~fclk;

    ups_axi4l_regs #(.NUM_REGS(4), .ADDR_WIDTH(32), .STRB_EN(1'b0), .RST_VAL(32'h0)) u_dut0 (
        .fclk(fclk), .rst_n(rst_n),
        .ca4l_awaddr(ca4l_awaddr), .ca4l_awprot(ca4l_awprot), .ca4l_awvalid(ca4l_awvalid), .ca4l_awready(awready_0),
        .ca4l_wdata(ca4l_wdata), .ca4l_wstrb(ca4l_wstrb), .ca4l_wvalid(ca4l_wvalid), .ca4l_wready(wready_0),
        .ca4l_bresp(bresp_0), .ca4l_bvalid(bvalid_0), .ca4l_bready(ca4l_bready),
        .ca4l_araddr(ca4l_araddr), .ca4l_arprot(ca4l_arprot), .ca4l_arvalid(ca4l_arvalid), .ca4l_arready(arready_0),
        .ca4l_rdata(rdata_0), .ca4l_rresp(rresp_0), .ca4l_rvalid(rvalid_0), .ca4l_rready(ca4l_rready),
        .reg_out(reg_out_0), .reg_wr_stb(reg_wr_stb_0)
    );

    ups_axi4l_regs #(.NUM_REGS(4), .ADDR_WIDTH(32), .STRB_EN(1'b1), .RST_VAL(32'h0)) u_dut1 (
        .fclk(fclk), .rst_n(rst_n),
        .ca4l_awaddr(ca4l_awaddr), .ca4l_awprot(ca4l_awprot), .ca4l_awvalid(ca4l_awvalid), .ca4l_awready(awready_1),
        .ca4l_wdata(ca4l_wdata), .ca4l_wstrb(ca4l_wstrb), .ca4l_wvalid(ca4l_wvalid), .ca4l_wready(wready_1),
        .ca4l_bresp(bresp_1), .ca4l_bvalid(bvalid_1), .ca4l_bready(ca4l_bready),
        .ca4l_araddr(ca4l_araddr), .ca4l_arprot(ca4l_arprot), .ca4l_arvalid(ca4l_arvalid), .ca4l_arready(arready_1),
        .ca4l_rdata(rdata_1), .ca4l_rresp(rresp_1), .ca4l_rvalid(rvalid_1), .ca4l_rready(ca4l_rready),
        .reg_out(reg_out_1), .reg_wr_stb(reg_wr_stb_1)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic [127:0] mdl_flat0();
        return {mdl0[3], mdl0[2], mdl0[1], mdl0[0]};
    endfunction

    function automatic logic [127:0] mdl_flat1();
        return {mdl1[3], mdl1[2], mdl1[1], mdl1[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdl0[i] = 32'h0;
            mdl1[i] = 32'h0;
        end
    endtask

    // sel: 0 = AW+W together, 1 = AW, 2 = W, 3 = AR. Returns at posedge+1 after the handshake edge.
    task automatic wait_hs(input int sel, input string tag);
        int  n;
        bit  rdy;
        n = 0;
        do begin
            @(negedge fclk);
            case (sel)
                0:       rdy = awready_0 && wready_0;
                1:       rdy = awready_0;
                2:       rdy = wready_0;
                default: rdy = arready_0;
            endcase
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check({tag, "_hs_timeout"}, 0, 1);
        @(posedge fclk);
        #1;
    endtask

    task automatic sb_pop_b(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_b_kind"}, e.is_rd, 0);
        check({tag, "_bresp0"}, bresp_0, e.resp);
        check({tag, "_bresp1"}, bresp_1, e.resp);
    endtask

    task automatic sb_pop_r(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_r_kind"}, e.is_rd, 1);
        check({tag, "_rresp0"}, rresp_0, e.resp);
        check({tag, "_rresp1"}, rresp_1, e.resp);
        check({tag, "_rdata0"}, rdata_0, e.data0);
        check({tag, "_rdata1"}, rdata_1, e.data1);
    endtask

    // mode: 0 = AW and W together, 1 = AW then W, 2 = W then AW.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input int b_hold);
        exp_t        e;
        int          idx;
        bit          in_rng;
        logic [31:0] m;
        logic [3:0]  exp_stb;

        idx    = int'(addr >> 2);
        in_rng = (idx < 4);
        e.is_rd = 0;
        e.resp  = in_rng ? 2'b00 : 2'b10;
        e.data0 = '0;
        e.data1 = '0;
        sb_q.push_back(e);
        exp_stb = '0;
        if (in_rng) begin
            m         = lane_mask(strb);
            mdl0[idx] = data;
            mdl1[idx] = (mdl1[idx] & ~m) | (data & m);
            exp_stb[idx] = 1'b1;
        end

        if (mode == 0) begin
            ca4l_awaddr = addr; ca4l_awvalid = 1'b1;
            ca4l_wdata = data; ca4l_wstrb = strb; ca4l_wvalid = 1'b1;
            #1;
            check({tag, "_ar_blocked"}, arready_0, 0);
            wait_hs(0, tag);
            ca4l_awvalid = 1'b0; ca4l_wvalid = 1'b0;
        end else if (mode == 1) begin
            ca4l_awaddr = addr; ca4l_awvalid = 1'b1;
            wait_hs(1, tag);
            ca4l_awvalid = 1'b0;
            check({tag, "_awh_ready"}, {awready_0, wready_0, bvalid_0}, 3'b010);
            ca4l_wdata = data; ca4l_wstrb = strb; ca4l_wvalid = 1'b1;
            wait_hs(2, tag);
            ca4l_wvalid = 1'b0;
        end else begin
            ca4l_wdata = data; ca4l_wstrb = strb; ca4l_wvalid = 1'b1;
            wait_hs(2, tag);
            ca4l_wvalid = 1'b0;
            check({tag, "_wh_ready"}, {awready_0, wready_0, bvalid_0}, 3'b100);
            ca4l_awaddr = addr; ca4l_awvalid = 1'b1;
            wait_hs(1, tag);
            ca4l_awvalid = 1'b0;
        end

        check({tag, "_bvalid_lat"}, {bvalid_0, bvalid_1}, 2'b11);
        check({tag, "_stb0"}, reg_wr_stb_0, exp_stb);
        check({tag, "_stb1"}, reg_wr_stb_1, exp_stb);

        for (int i = 0; i < b_hold; i++) begin
            @(posedge fclk);
            #1;
            check({tag, "_hold_bvalid"}, bvalid_0, 1);
            check({tag, "_hold_bresp"}, bresp_0, e.resp);
            check({tag, "_hold_arready"}, arready_0, 0);
        end

        ca4l_bready = 1'b1;
        @(negedge fclk);
        check({tag, "_b_hs"}, bvalid_0 && bvalid_1, 1);
        sb_pop_b(tag);
        @(posedge fclk);
        #1;
        ca4l_bready = 1'b0;
        check({tag, "_bvalid_drop"}, {bvalid_0, bvalid_1}, 2'b00);
        check({tag, "_stb_clear"}, {reg_wr_stb_0, reg_wr_stb_1}, 8'h00);
        check({tag, "_regs0"}, reg_out_0, mdl_flat0());
        check({tag, "_regs1"}, reg_out_1, mdl_flat1());
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr);
        exp_t e;
        int   idx;
        bit   in_rng;

        idx    = int'(addr >> 2);
        in_rng = (idx < 4);
        e.is_rd = 1;
        e.resp  = in_rng ? 2'b00 : 2'b10;
        e.data0 = in_rng ? mdl0[idx] : 32'h0;
        e.data1 = in_rng ? mdl1[idx] : 32'h0;
        sb_q.push_back(e);

        ca4l_araddr = addr; ca4l_arvalid = 1'b1;
        wait_hs(3, tag);
        ca4l_arvalid = 1'b0;
        check({tag, "_rvalid_lat"}, {rvalid_0, rvalid_1}, 2'b11);
        ca4l_rready = 1'b1;
        @(negedge fclk);
        check({tag, "_r_hs"}, rvalid_0 && rvalid_1, 1);
        sb_pop_r(tag);
        @(posedge fclk);
        #1;
        ca4l_rready = 1'b0;
        check({tag, "_rvalid_drop"}, {rvalid_0, rvalid_1}, 2'b00);
        check({tag, "_rdata_clear"}, rdata_0, 32'h0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_ready", {awready_0, wready_0, arready_0, awready_1, wready_1, arready_1}, 6'b0);
        check("rst_valid", {bvalid_0, rvalid_0, bvalid_1, rvalid_1}, 4'b0);
        check("rst_resp_data", {bresp_0, rresp_0, rdata_0}, 36'h0);
        check("rst_regs", reg_out_0, 128'h0);
        check("rst_stb", {reg_wr_stb_0, reg_wr_stb_1}, 8'h0);
        @(posedge fclk);
        #1;
        rst_n = 1'b1;
        @(posedge fclk);
        #1;

        axi_write("wr0", 32'h0, 32'h2, 4'b0000, 0, 0);
        axi_read ("rd0", 32'h0);
        axi_write("wr4", 32'h4, 32'h11, 4'b0000, 1, 0);
        axi_read ("rd4", 32'h4);
        axi_write("wr8", 32'h8, 32'hC38D, 4'b0000, 2, 0);
        check("reg2_out", reg_out_0[95:64], 32'h0000C38D);
        axi_write("wrC_hold", 32'hC, 32'hA5A50F0F, 4'b1111, 0, 5);
        axi_read ("rdC", 32'hC);

        axi_write("wr_oor", 32'h10, 32'hDEAD, 4'b1111, 0, 0);
        axi_read ("rd_oor", 32'h10);

        axi_write("wr4_ones", 32'h4, 32'hFFFFFFFF, 4'b1111, 1, 0);
        axi_write("wr4_strb", 32'h4, 32'h12345678, 4'b0011, 2, 0);
        axi_read ("rd4_strb", 32'h4);
        check("strb_reg1", reg_out_1[63:32], 32'hFFFF5678);

        ca4l_awaddr = 32'h0; ca4l_awvalid = 1'b1;
        wait_hs(1, "mid_rst");
        ca4l_awvalid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ready", {awready_0, wready_0, arready_0, awready_1, wready_1, arready_1}, 6'b0);
        check("mid_rst_valid", {bvalid_0, rvalid_0, bvalid_1, rvalid_1}, 4'b0);
        check("mid_rst_regs0", reg_out_0, mdl_flat0());
        check("mid_rst_regs1", reg_out_1, mdl_flat1());
        @(posedge fclk);
        #1;
        rst_n = 1'b1;
        @(posedge fclk);
        #1;
        check("post_rst_valid", {bvalid_0, rvalid_0}, 2'b00);

        axi_write("post_wr0", 32'h0, 32'h77, 4'b1111, 0, 0);
        axi_read ("post_rd0", 32'h0);
        axi_read ("post_rd8", 32'h8);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
